// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: 4-digit BCD entry buffer with backspace/clear/enter,
// committed-value publication, and multiplexed 7-segment display scanning.
module keypad_entry_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [2:0]  count,
    output logic        full,
    output logic        locked,
    output logic [7:0]  seg,
    output logic [3:0]  cs
);

    localparam int unsigned DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MAX_DIGITS = 4;

    localparam logic [3:0] KEY_BSP = 4'hA;
    localparam logic [3:0] KEY_CLR = 4'hB;
    localparam logic [3:0] KEY_ENT = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    logic [15:0]        r_buf;
    logic [2:0]         r_count;
    logic [15:0]        r_value;
    logic               r_value_valid;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_idx;
    logic [7:0]         r_seg;
    logic [3:0]         r_cs;

    state_t             w_state_nx;
    logic [15:0]        w_buf_nx;
    logic [2:0]         w_count_nx;
    logic [15:0]        w_value_nx;
    logic               w_value_valid_nx;
    logic               w_is_digit;
    logic [3:0]         w_slot_digit;
    logic               w_slot_on;
    logic [7:0]         w_seg_nx;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Entry state and datapath registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_buf         <= 16'h0000;
            r_count       <= 3'd0;
            r_value       <= 16'h0000;
            r_value_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_buf         <= w_buf_nx;
            r_count       <= w_count_nx;
            r_value       <= w_value_nx;
            r_value_valid <= w_value_valid_nx;
        end
    end

    assign w_is_digit = (key_code <= 4'd9);

    // Key decode: next entry state, buffer, count and commit
    always_comb begin
        w_state_nx       = r_state;
        w_buf_nx         = r_buf;
        w_count_nx       = r_count;
        w_value_nx       = r_value;
        w_value_valid_nx = 1'b0;
        if (key_valid) begin
            if (w_is_digit) begin
                case (r_state)
                    ST_ENTRY: begin
                        if (r_count < 3'(MAX_DIGITS)) begin
                            w_buf_nx   = {r_buf[11:0], key_code};
                            w_count_nx = r_count + 3'd1;
                        end
                    end
                    default: begin
                        w_buf_nx   = {12'h000, key_code};
                        w_count_nx = 3'd1;
                        w_state_nx = ST_ENTRY;
                    end
                endcase
            end else if (key_code == KEY_BSP) begin
                if (r_state == ST_ENTRY) begin
                    w_buf_nx   = {4'h0, r_buf[15:4]};
                    w_count_nx = r_count - 3'd1;
                    if (r_count == 3'd1) begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end else if (key_code == KEY_CLR) begin
                w_buf_nx   = 16'h0000;
                w_count_nx = 3'd0;
                w_state_nx = ST_IDLE;
            end else if (key_code == KEY_ENT) begin
                if (r_state == ST_ENTRY) begin
                    w_value_nx       = r_buf;
                    w_value_valid_nx = 1'b1;
                    w_state_nx       = ST_LOCKED;
                end
            end
        end
    end

    // Free-running digit scan, unaffected by key traffic
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_slot_digit = r_buf[{r_idx, 2'b00} +: 4];
    assign w_slot_on    = (3'(r_idx) < r_count) || ((r_idx == 2'd0) && (r_count == 3'd0));

    // Leading slots beyond the entered digits stay blank; dp marks a locked value
    always_comb begin
        w_seg_nx = 8'hFF;
        if (w_slot_on) begin
            w_seg_nx = seg_encode(w_slot_digit);
            if ((r_state == ST_LOCKED) && (r_idx == 2'd0)) begin
                w_seg_nx[7] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_seg <= 8'hFF;
            r_cs  <= 4'b1111;
        end else begin
            r_seg <= w_seg_nx;
            r_cs  <= ~(4'b0001 << r_idx);
        end
    end

    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign count       = r_count;
    assign full        = (r_count == 3'(MAX_DIGITS));
    assign locked      = (r_state == ST_LOCKED);
    assign seg         = r_seg;
    assign cs          = r_cs;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: queue-based entry model plus time-based scan model,
// compared against the DUT every cycle, with directed key sequences.
module tb_keypad_entry_ctrl;

    localparam int unsigned SD = 4;

    logic        clk;
    logic        RST;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  count;
    logic        full;
    logic        locked;
    logic [7:0]  seg;
    logic [3:0]  cs;

    int n_tests;
    int n_fail;

    // Model: entered digits oldest-first, lock flag, commit value, cycles since reset
    int          q[$];
    bit          m_locked;
    logic [15:0] m_value;
    bit          m_vv;
    int          m_ticks;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_cs;

    keypad_entry_ctrl #(.SCAN_DIV(SD)) dut (
        .clk         (clk),
        .RST         (RST),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value       (value),
        .value_valid (value_valid),
        .count       (count),
        .full        (full),
        .locked      (locked),
        .seg         (seg),
        .cs          (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] enc(input int d);
        logic [7:0] t [10];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    // i-th digit counted from the newest; absent digits read as zero
    function automatic int dig(input int i);
        if (i < q.size()) return q[q.size() - 1 - i];
        return 0;
    endfunction

    function automatic logic [15:0] m_buf();
        return {4'(dig(3)), 4'(dig(2)), 4'(dig(1)), 4'(dig(0))};
    endfunction

    task automatic model_reset();
        q.delete();
        m_locked = 1'b0;
        m_value  = 16'h0000;
        m_vv     = 1'b0;
        m_ticks  = 0;
        exp_seg  = 8'hFF;
        exp_cs   = 4'hF;
    endtask

    task automatic model_step();
        int slot;
        if (RST) begin
            model_reset();
            return;
        end
        slot   = (m_ticks / SD) % 4;
        exp_cs = ~(4'b0001 << slot);
        if (slot < q.size() || (slot == 0 && q.size() == 0)) begin
            exp_seg = enc(dig(slot));
            if (m_locked && slot == 0) exp_seg[7] = 1'b0;
        end else begin
            exp_seg = 8'hFF;
        end
        m_ticks++;
        m_vv = 1'b0;
        if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (m_locked || q.size() == 0) begin
                    q.delete();
                    q.push_back(int'(key_code));
                    m_locked = 1'b0;
                end else if (q.size() < 4) begin
                    q.push_back(int'(key_code));
                end
            end else if (key_code == 4'hA) begin
                if (!m_locked && q.size() > 0) void'(q.pop_back());
            end else if (key_code == 4'hB) begin
                q.delete();
                m_locked = 1'b0;
            end else if (key_code == 4'hE) begin
                if (!m_locked && q.size() > 0) begin
                    m_value  = m_buf();
                    m_vv     = 1'b1;
                    m_locked = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 4));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("value", 32'(value), 32'(m_value));
        chk("value_valid", 32'(value_valid), 32'(m_vv));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("cs", 32'(cs), 32'(exp_cs));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        cyc();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic wait_slot(input int k);
        logic [3:0] want;
        bit ok;
        want = ~(4'b0001 << k);
        ok   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cs === want) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk("wait_slot", 32'(ok), 32'd1);
    endtask

    task automatic mid_cycle_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_vv", 32'(value_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_cs", 32'(cs), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        RST       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        cycles(2);
        chk("reset_cs", 32'(cs), 32'hF);
        chk("reset_seg", 32'(seg), 32'hFF);
        RST = 1'b0;

        // Idle scan: slot 0 shows "0", others blank
        cycles(20);
        wait_slot(0);
        chk("idle_slot0", 32'(seg), 32'hC0);
        wait_slot(1);
        chk("idle_slot1", 32'(seg), 32'hFF);

        // 1,2,3 enter
        press(4'h1); press(4'h2); press(4'h3);
        chk("count3", 32'(count), 32'd3);
        press(4'hE);
        chk("pin_m_value", 32'(m_value), 32'h0123);
        chk("commit_value", 32'(value), 32'h0123);
        chk("commit_pulse", 32'(value_valid), 32'h1);
        cyc();
        chk("commit_pulse_end", 32'(value_valid), 32'h0);
        chk("locked", 32'(locked), 32'h1);
        wait_slot(0); chk("lock_slot0", 32'(seg), 32'h30);
        wait_slot(1); chk("lock_slot1", 32'(seg), 32'hA4);
        wait_slot(2); chk("lock_slot2", 32'(seg), 32'hF9);
        wait_slot(3); chk("lock_slot3", 32'(seg), 32'hFF);

        // Overflow, backspace, commit
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        chk("pin_buf_full", 32'(m_buf()), 32'h9876);
        chk("full", 32'(full), 32'h1);
        press(4'hA); press(4'hA);
        chk("pin_buf_bsp", 32'(m_buf()), 32'h0098);
        chk("count_bsp", 32'(count), 32'd2);
        press(4'hE);
        chk("commit2", 32'(value), 32'h0098);

        // New entry from locked, clear, enter in idle
        press(4'h4);
        chk("relock_count", 32'(count), 32'd1);
        chk("relock_value", 32'(value), 32'h0098);
        wait_slot(0); chk("relock_dp_off", 32'(seg), 32'h99);
        press(4'hB);
        chk("clear_count", 32'(count), 32'd0);
        press(4'hE);
        chk("idle_enter_nopulse", 32'(value_valid), 32'h0);

        // Ignored codes and idle backspace
        press(4'hC); press(4'hF); press(4'hA); press(4'hD);
        chk("ignored_count", 32'(count), 32'd0);
        chk("ignored_value", 32'(value), 32'h0098);

        // Key coincident with scan wrap 3->0
        for (int i = 0; i < 32 && (m_ticks % 16) != 15; i++) cyc();
        chk("align_wrap", 32'(m_ticks % 16), 32'd15);
        press(4'h5);
        chk("wrap_cs3", 32'(cs), 32'h7);
        chk("wrap_count", 32'(count), 32'd1);
        cyc();
        chk("wrap_cs0", 32'(cs), 32'hE);
        chk("wrap_seg", 32'(seg), 32'h92);

        // Reset during entry
        press(4'h6);
        chk("pre_rst_count", 32'(count), 32'd2);
        mid_cycle_reset();
        cycles(10);

        // Reset during the commit pulse
        press(4'h1);
        press(4'hE);
        chk("pre_rst_pulse", 32'(value_valid), 32'h1);
        mid_cycle_reset();
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
